// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared constants, op codes and FSM encoding for the ALU sharing controller
package alu_pkg;

    localparam int ALU_W   = 4;
    localparam int ALU_OPW = 3;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_NOT = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;
    localparam logic [2:0] OP_NEZ = 3'b110;
    localparam logic [2:0] OP_EQ  = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/alu_share_ctrl_if.sv
// rtl/alu_share_ctrl_if.sv - requester, shared-ALU and response signals of the sharing controller
import alu_pkg::*;

interface alu_share_ctrl_if #(
    parameter int W   = ALU_W,
    parameter int OPW = ALU_OPW
);
    logic           r0_valid;
    logic           r0_ready;
    logic [OPW-1:0] r0_op;
    logic [W-1:0]   r0_a;
    logic [W-1:0]   r0_b;

    logic           r1_valid;
    logic           r1_ready;
    logic [OPW-1:0] r1_op;
    logic [W-1:0]   r1_a;
    logic [W-1:0]   r1_b;

    logic [OPW-1:0] alu_op;
    logic [W-1:0]   alu_a;
    logic [W-1:0]   alu_b;
    logic [W-1:0]   alu_res;

    logic           resp_valid;
    logic           resp_ready;
    logic [W-1:0]   resp_data;
    logic           resp_id;

    // Controller side
    modport master (
        input  r0_valid, r0_op, r0_a, r0_b,
        output r0_ready,
        input  r1_valid, r1_op, r1_a, r1_b,
        output r1_ready,
        output alu_op, alu_a, alu_b,
        input  alu_res,
        output resp_valid, resp_data, resp_id,
        input  resp_ready
    );

    // Requesters, ALU and result consumer side
    modport slave (
        output r0_valid, r0_op, r0_a, r0_b,
        input  r0_ready,
        output r1_valid, r1_op, r1_a, r1_b,
        input  r1_ready,
        input  alu_op, alu_a, alu_b,
        output alu_res,
        input  resp_valid, resp_data, resp_id,
        output resp_ready
    );

endinterface

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin picker
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       gnt_valid,
    output logic       gnt_id
);

    // A lone requester always wins; on a tie the one not served last wins.
    always_comb begin
        gnt_valid = |req;
        if (req == 2'b11) begin
            gnt_id = ~last_grant;
        end else begin
            gnt_id = req[1];
        end
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// rtl/alu_share_ctrl.sv - shares one combinational ALU between two requesters
import alu_pkg::*;

module alu_share_ctrl #(
    parameter int W   = ALU_W,
    parameter int OPW = ALU_OPW
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_share_ctrl_if.master bus
);

    state_e         state_q, state_d;
    logic [OPW-1:0] op_q, op_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic [W-1:0]   resp_data_q, resp_data_d;
    logic           resp_id_q, resp_id_d;
    logic           resp_valid_q, resp_valid_d;
    logic           last_grant_q, last_grant_d;

    logic           gnt_valid;
    logic           gnt_id;
    logic           accept;

    rr_arb2 u_arb (
        .req        ({bus.r1_valid, bus.r0_valid}),
        .last_grant (last_grant_q),
        .gnt_valid  (gnt_valid),
        .gnt_id     (gnt_id)
    );

    // Ready is only offered in IDLE, to the arbiter's pick, and never while reset is held.
    always_comb begin
        accept       = rst_n && (state_q == IDLE) && gnt_valid;
        bus.r0_ready = accept && !gnt_id;
        bus.r1_ready = accept && gnt_id;
    end

    // Next-state logic: latch operands on accept, capture the ALU result after EXEC, hold in RESP.
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        resp_data_d  = resp_data_q;
        resp_id_d    = resp_id_q;
        resp_valid_d = resp_valid_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    op_d         = gnt_id ? bus.r1_op : bus.r0_op;
                    a_d          = gnt_id ? bus.r1_a  : bus.r0_a;
                    b_d          = gnt_id ? bus.r1_b  : bus.r0_b;
                    resp_id_d    = gnt_id;
                    last_grant_d = gnt_id;
                    state_d      = EXEC;
                end
            end
            EXEC: begin
                resp_data_d  = bus.alu_res;
                resp_valid_d = 1'b1;
                state_d      = RESP;
            end
            RESP: begin
                if (bus.resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: begin
                resp_valid_d = 1'b0;
                state_d      = IDLE;
            end
        endcase
    end

    // State and output registers; an asynchronous reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            resp_data_q  <= '0;
            resp_id_q    <= 1'b0;
            resp_valid_q <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            resp_data_q  <= resp_data_d;
            resp_id_q    <= resp_id_d;
            resp_valid_q <= resp_valid_d;
            last_grant_q <= last_grant_d;
        end
    end

    // The ALU always sees the operand register; responses come straight from their flops.
    always_comb begin
        bus.alu_op     = op_q;
        bus.alu_a      = a_q;
        bus.alu_b      = b_q;
        bus.resp_valid = resp_valid_q;
        bus.resp_data  = resp_data_q;
        bus.resp_id    = resp_id_q;
    end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// tb/tb_alu_share_ctrl.sv - directed vector bench for the ALU sharing controller
`timescale 1ns/1ps
import alu_pkg::*;

module tb_alu_share_ctrl;

    typedef struct {
        logic       id;
        logic [2:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   tests = 0;
    int   fails = 0;

    alu_share_ctrl_if bus ();

    alu_share_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Shared ALU instance seen by the controller
    function automatic logic [3:0] alu_f(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_NOT:  return ~a;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_NEZ:  return {3'b000, (a != b)};
            default: return {3'b000, (a == b)};
        endcase
    endfunction

    always_comb bus.alu_res = alu_f(bus.alu_op, bus.alu_a, bus.alu_b);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic id, input logic v, input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        if (id) begin
            bus.r1_valid = v; bus.r1_op = op; bus.r1_a = a; bus.r1_b = b;
        end else begin
            bus.r0_valid = v; bus.r0_op = op; bus.r0_a = a; bus.r0_b = b;
        end
    endtask

    // One isolated transaction from IDLE with resp_ready high, checked cycle by cycle.
    task automatic run_vec(input vec_t v, input string tag);
        bus.r0_valid   = 1'b0;
        bus.r1_valid   = 1'b0;
        bus.resp_ready = 1'b1;
        drive_req(v.id, 1'b1, v.op, v.a, v.b);
        #1;
        check({tag, "_ready"}, v.id ? bus.r1_ready : bus.r0_ready, 1);
        check({tag, "_other_ready"}, v.id ? bus.r0_ready : bus.r1_ready, 0);
        tick();
        check({tag, "_exec_valid"}, bus.resp_valid, 0);
        check({tag, "_exec_op"}, bus.alu_op, v.op);
        check({tag, "_exec_a"}, bus.alu_a, v.a);
        check({tag, "_exec_b"}, bus.alu_b, v.b);
        check({tag, "_exec_ready"}, {bus.r1_ready, bus.r0_ready}, 0);
        drive_req(v.id, 1'b0, v.op, v.a, v.b);
        tick();
        check({tag, "_resp_valid"}, bus.resp_valid, 1);
        check({tag, "_resp_data"}, bus.resp_data, v.exp);
        check({tag, "_resp_id"}, bus.resp_id, v.id);
        tick();
        check({tag, "_idle_valid"}, bus.resp_valid, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1);
    end

    initial begin
        vec_t vecs[10];
        int   cnt;
        int   acc;
        int   rsp;
        int   last;
        logic exp_id;

        vecs[0] = '{id: 1'b0, op: OP_ADD, a: 4'h3, b: 4'h4, exp: 4'h7};
        vecs[1] = '{id: 1'b1, op: OP_SUB, a: 4'h2, b: 4'h5, exp: 4'hD};
        vecs[2] = '{id: 1'b0, op: OP_ADD, a: 4'hF, b: 4'h1, exp: 4'h0};
        vecs[3] = '{id: 1'b1, op: OP_NOT, a: 4'h5, b: 4'h0, exp: 4'hA};
        vecs[4] = '{id: 1'b0, op: OP_AND, a: 4'hC, b: 4'hA, exp: 4'h8};
        vecs[5] = '{id: 1'b1, op: OP_OR,  a: 4'hC, b: 4'h3, exp: 4'hF};
        vecs[6] = '{id: 1'b0, op: OP_XOR, a: 4'h6, b: 4'h3, exp: 4'h5};
        vecs[7] = '{id: 1'b1, op: OP_NEZ, a: 4'h3, b: 4'h3, exp: 4'h0};
        vecs[8] = '{id: 1'b0, op: OP_NEZ, a: 4'h3, b: 4'h4, exp: 4'h1};
        vecs[9] = '{id: 1'b1, op: OP_EQ,  a: 4'h7, b: 4'h7, exp: 4'h1};

        // Reset values, with a requester already asking
        rst_n = 1'b0;
        bus.resp_ready = 1'b1;
        drive_req(1'b0, 1'b1, OP_ADD, 4'h1, 4'h1);
        drive_req(1'b1, 1'b0, OP_ADD, 4'h0, 4'h0);
        #2;
        check("rst_resp_valid", bus.resp_valid, 0);
        check("rst_resp_data", bus.resp_data, 0);
        check("rst_resp_id", bus.resp_id, 0);
        check("rst_alu_op", bus.alu_op, 0);
        check("rst_alu_a", bus.alu_a, 0);
        check("rst_alu_b", bus.alu_b, 0);
        check("rst_r0_ready", bus.r0_ready, 0);
        bus.r0_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;

        // Both requesters valid from the first cycle: grants alternate starting with r0
        drive_req(1'b0, 1'b1, OP_EQ,  4'h9, 4'h9);
        drive_req(1'b1, 1'b1, OP_XOR, 4'hA, 4'h5);
        #1;
        check("tie_r0_ready", bus.r0_ready, 1);
        check("tie_r1_ready", bus.r1_ready, 0);
        for (int k = 0; k < 4; k++) begin
            cnt = 0;
            while (!bus.resp_valid && cnt < 10) begin
                tick();
                cnt++;
            end
            exp_id = (k % 2 == 1);
            check("tie_latency", cnt, 2);
            check("tie_resp_valid", bus.resp_valid, 1);
            check("tie_resp_id", bus.resp_id, exp_id);
            check("tie_resp_data", bus.resp_data, exp_id ? 4'hF : 4'h1);
            if (k == 3) begin
                bus.r0_valid = 1'b0;
                bus.r1_valid = 1'b0;
            end
            tick();
        end
        check("tie_done_valid", bus.resp_valid, 0);

        // Single-requester vectors covering every op and the wrap cases
        for (int i = 0; i < 10; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Backpressure: RESP held 5 cycles with r0 waiting
        drive_req(1'b1, 1'b1, OP_OR, 4'hC, 4'h3);
        bus.resp_ready = 1'b0;
        #1;
        check("bp_accept", bus.r1_ready, 1);
        tick();
        bus.r1_valid = 1'b0;
        drive_req(1'b0, 1'b1, OP_ADD, 4'h1, 4'h1);
        #1;
        check("bp_exec_ready", {bus.r1_ready, bus.r0_ready}, 0);
        tick();
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", bus.resp_valid, 1);
            check("bp_data", bus.resp_data, 4'hF);
            check("bp_id", bus.resp_id, 1);
            check("bp_ready", {bus.r1_ready, bus.r0_ready}, 0);
            check("bp_alu", {bus.alu_op, bus.alu_a, bus.alu_b}, {OP_OR, 4'hC, 4'h3});
            tick();
        end
        bus.resp_ready = 1'b1;
        #1;
        check("bp_release_valid", bus.resp_valid, 1);
        tick();
        check("bp_handshake_once", bus.resp_valid, 0);
        check("bp_next_ready", bus.r0_ready, 1);
        bus.r0_valid = 1'b0;
        tick();
        check("bp_no_second", bus.resp_valid, 0);
        check("bp_no_accept", bus.alu_op, OP_OR);

        // Reset pulsed during EXEC aborts the operation and restores last_grant
        drive_req(1'b0, 1'b1, OP_ADD, 4'h5, 4'h6);
        #1;
        tick();
        bus.r0_valid = 1'b0;
        check("rx_exec_a", bus.alu_a, 4'h5);
        rst_n = 1'b0;
        bus.r1_valid = 1'b1;
        #1;
        check("rx_resp_valid", bus.resp_valid, 0);
        check("rx_resp_data", bus.resp_data, 0);
        check("rx_resp_id", bus.resp_id, 0);
        check("rx_alu", {bus.alu_op, bus.alu_a, bus.alu_b}, 0);
        check("rx_ready", {bus.r1_ready, bus.r0_ready}, 0);
        bus.r1_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("rx_no_resp", bus.resp_valid, 0);
            tick();
        end
        drive_req(1'b0, 1'b1, OP_ADD, 4'h5, 4'h6);
        drive_req(1'b1, 1'b1, OP_SUB, 4'h1, 4'h1);
        #1;
        check("rx_tie_r0", bus.r0_ready, 1);
        check("rx_tie_r1", bus.r1_ready, 0);
        run_vec('{id: 1'b0, op: OP_ADD, a: 4'h5, b: 4'h6, exp: 4'hB}, "rx_after");

        // Back-to-back issue from r0 alone: one accept every 3 cycles
        bus.r1_valid = 1'b0;
        bus.resp_ready = 1'b1;
        drive_req(1'b0, 1'b1, OP_ADD, 4'h2, 4'h3);
        #1;
        acc = 0;
        rsp = 0;
        last = -1;
        for (int c = 0; c < 30; c++) begin
            if (bus.r0_ready) begin
                if (last >= 0) check("tput_interval", c - last, 3);
                last = c;
                acc++;
            end
            if (bus.resp_valid) begin
                rsp++;
                check("tput_id", bus.resp_id, 0);
                check("tput_data", bus.resp_data, 4'h5);
            end
            tick();
        end
        bus.r0_valid = 1'b0;
        check("tput_accepts", acc, 10);
        check("tput_responses", rsp, 10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
